// File: rtl/pzbcm_credit_return.sv
// ---------------------------------------------------------------------------
// pzbcm_credit_return
//   Receiver-side credit manager for credit-based flow control. Counts buffer
//   slots freed by the local consumer and hands them back to the remote
//   sender as batched credit transfers on a valid/ready handshake. After
//   reset or i_clear the block first advertises the initial credit grant.
//
// Ports
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_clear         synchronous re-initialise (link retrain), highest priority
//   i_release       one buffer slot freed this cycle
//   i_flush         return all pending credits now, regardless of batch size
//   o_credit_valid  credit transfer valid
//   i_credit_ready  sender accepts the transfer
//   o_credit_count  credits carried by the current transfer
//   o_pending       credits accumulated but not yet in a transfer
//   o_init_done     initial grant accepted; block is in RUN
//   o_error         sticky: release overflow or release before init done
// ---------------------------------------------------------------------------
module pzbcm_credit_return #(
  parameter int MAX_CREDITS     = 8,
  parameter int INITIAL_CREDITS = MAX_CREDITS,
  parameter int BATCH_SIZE      = 4,
  parameter int TIMEOUT_CYCLES  = 16,
  localparam int CW             = $clog2(MAX_CREDITS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_release,
  input  logic          i_flush,
  output logic          o_credit_valid,
  input  logic          i_credit_ready,
  output logic [CW-1:0] o_credit_count,
  output logic [CW-1:0] o_pending,
  output logic          o_init_done,
  output logic          o_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic TIMER_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] INIT_CNT  = CW'(INITIAL_CREDITS);
  localparam logic [CW-1:0] BATCH_CNT = CW'(BATCH_SIZE);
  localparam logic [CW:0]   MAX_CNT   = (CW + 1)'(MAX_CREDITS);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_INIT_WAIT = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t          state_r,     state_s;
  logic            valid_r,     valid_s;
  logic [CW-1:0]   count_r,     count_s;
  logic [CW-1:0]   pending_r,   pending_s;
  logic [TW-1:0]   timer_r,     timer_s;
  logic            init_done_r, init_done_s;
  logic            error_r,     error_s;

  logic [CW:0]     outstanding_s;
  logic            accept_s;
  logic [CW-1:0]   pend_plus_s;
  logic            expire_s;
  logic            launch_s;

  // Next-state and next-output computation for the credit FSM.
  always_comb begin
    state_s     = state_r;
    valid_s     = valid_r;
    count_s     = count_r;
    pending_s   = pending_r;
    timer_s     = timer_r;
    init_done_s = init_done_r;
    error_s     = error_r;

    // Credits this block is responsible for: still pending plus in flight.
    outstanding_s = {1'b0, pending_r} + (valid_r ? {1'b0, count_r} : {(CW + 1){1'b0}});
    accept_s      = i_release && (outstanding_s < MAX_CNT);
    pend_plus_s   = pending_r + CW'(accept_s);
    expire_s      = TIMER_EN && (pending_r != {CW{1'b0}}) && (timer_r == TIMER_LAST);
    launch_s      = 1'b0;

    if (i_clear) begin
      state_s     = ST_INIT;
      valid_s     = 1'b0;
      count_s     = {CW{1'b0}};
      pending_s   = {CW{1'b0}};
      timer_s     = {TW{1'b0}};
      init_done_s = 1'b0;
      error_s     = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          // Releases before the grant is accepted are dropped and flagged.
          if (i_release) error_s = 1'b1;
          else           error_s = error_r;
          if (INIT_CNT != {CW{1'b0}}) begin
            valid_s = 1'b1;
            count_s = INIT_CNT;
            state_s = ST_INIT_WAIT;
          end else begin
            init_done_s = 1'b1;
            state_s     = ST_RUN;
          end
        end

        ST_INIT_WAIT: begin
          if (i_release) error_s = 1'b1;
          else           error_s = error_r;
          if (valid_r && i_credit_ready) begin
            valid_s     = 1'b0;
            count_s     = {CW{1'b0}};
            init_done_s = 1'b1;
            state_s     = ST_RUN;
          end else begin
            state_s = ST_INIT_WAIT;
          end
        end

        ST_RUN: begin
          if (i_release && !accept_s) error_s = 1'b1;
          else                        error_s = error_r;

          if (valid_r) begin
            // Transfer in flight: hold it; the accepting edge never relaunches.
            if (i_credit_ready) begin
              valid_s = 1'b0;
              count_s = {CW{1'b0}};
            end else begin
              valid_s = 1'b1;
            end
            pending_s = pend_plus_s;
            if (pending_r == {CW{1'b0}}) timer_s = {TW{1'b0}};
            else                         timer_s = timer_r;
          end else begin
            launch_s = (pending_r >= BATCH_CNT) ||
                       (i_flush && (pend_plus_s != {CW{1'b0}})) ||
                       expire_s;
            if (launch_s) begin
              valid_s   = 1'b1;
              count_s   = pend_plus_s;
              pending_s = {CW{1'b0}};
              timer_s   = {TW{1'b0}};
            end else begin
              pending_s = pend_plus_s;
              if (pending_r == {CW{1'b0}}) timer_s = {TW{1'b0}};
              else if (TIMER_EN)           timer_s = timer_r + TW'(1'b1);
              else                         timer_s = {TW{1'b0}};
            end
          end
        end

        default: begin
          state_s     = ST_INIT;
          valid_s     = 1'b0;
          count_s     = {CW{1'b0}};
          pending_s   = {CW{1'b0}};
          timer_s     = {TW{1'b0}};
          init_done_s = 1'b0;
          error_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_INIT;
      valid_r     <= 1'b0;
      count_r     <= {CW{1'b0}};
      pending_r   <= {CW{1'b0}};
      timer_r     <= {TW{1'b0}};
      init_done_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      valid_r     <= valid_s;
      count_r     <= count_s;
      pending_r   <= pending_s;
      timer_r     <= timer_s;
      init_done_r <= init_done_s;
      error_r     <= error_s;
    end
  end

  assign o_credit_valid = valid_r;
  assign o_credit_count = count_r;
  assign o_pending      = pending_r;
  assign o_init_done    = init_done_r;
  assign o_error        = error_r;

endmodule

// File: tb/tb_pzbcm_credit_return.sv
// ---------------------------------------------------------------------------
// tb_pzbcm_credit_return
//   Self-checking bench for pzbcm_credit_return: directed scenarios with
//   hand-derived expectations, then randomized traffic compared every cycle
//   against a credit-accounting reference model.
// ---------------------------------------------------------------------------
module tb_pzbcm_credit_return;

  localparam int MAX   = 8;
  localparam int INIT  = 8;
  localparam int BATCH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(MAX + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          rel   = 1'b0;
  logic          flush = 1'b0;
  logic          rdy   = 1'b0;
  logic          o_credit_valid;
  logic [CW-1:0] o_credit_count;
  logic [CW-1:0] o_pending;
  logic          o_init_done;
  logic          o_error;

  int checks = 0;
  int errors = 0;

  // Reference model: credits owed to the sender, credits in flight, and how
  // long the oldest pending credit has been waiting while the link was idle.
  int m_phase;   // 0: grant not yet issued, 1: grant offered, 2: running
  int m_inflight;
  int m_pend;
  int m_wait;
  bit m_done;
  bit m_err;

  always #5 clk = ~clk;

  pzbcm_credit_return #(
    .MAX_CREDITS     (MAX),
    .INITIAL_CREDITS (INIT),
    .BATCH_SIZE      (BATCH),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_clear        (clr),
    .i_release      (rel),
    .i_flush        (flush),
    .o_credit_valid (o_credit_valid),
    .i_credit_ready (rdy),
    .o_credit_count (o_credit_count),
    .o_pending      (o_pending),
    .o_init_done    (o_init_done),
    .o_error        (o_error)
  );

  task automatic model_reset();
    m_phase = 0; m_inflight = 0; m_pend = 0; m_wait = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit r, input bit f, input bit k, input bit c);
    int total;
    bit fire;
    if (c) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (r) m_err = 1;
      if (INIT > 0) begin m_inflight = INIT; m_phase = 1; end
      else begin m_phase = 2; m_done = 1; end
    end else if (m_phase == 1) begin
      if (r) m_err = 1;
      if (k) begin m_inflight = 0; m_phase = 2; m_done = 1; end
    end else begin
      // A slot release is only accepted while fewer than MAX credits are owed.
      total = m_pend;
      if (r) begin
        if (m_pend + m_inflight < MAX) total = m_pend + 1;
        else m_err = 1;
      end
      if (m_inflight > 0) begin
        if (k) m_inflight = 0;
        m_pend = total;
        if (m_pend == 0) m_wait = 0;
      end else begin
        fire = (m_pend >= BATCH) || (f && total > 0) ||
               (TMO > 0 && m_pend > 0 && m_wait >= TMO - 1);
        if (fire) begin
          m_inflight = total; m_pend = 0; m_wait = 0;
        end else begin
          m_wait = (m_pend == 0) ? 0 : m_wait + 1;
          m_pend = total;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, then sample.
  task automatic step(input bit r, input bit f, input bit k, input bit c);
    rel = r; flush = f; rdy = k; clr = c;
    @(posedge clk);
    #1;
    model_edge(r, f, k, c);
    rel = 1'b0; flush = 1'b0; rdy = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rel = 1'b0; flush = 1'b0; rdy = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({o_credit_valid, o_credit_count, o_pending, o_init_done, o_error} !== {1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got v=%b c=%0d p=%0d d=%b e=%b want all zero",
               o_credit_valid, o_credit_count, o_pending, o_init_done, o_error);
    end
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 1, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(8) || o_init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_grant: got v=%b c=%0d d=%b want v=1 c=8 d=0", o_credit_valid, o_credit_count, o_init_done);
    end
    step(0, 0, 1, 0);
    checks++;
    if (o_credit_valid !== 1'b0 || o_init_done !== 1'b1 || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL init_accept: got v=%b d=%b p=%0d want v=0 d=1 p=0", o_credit_valid, o_init_done, o_pending);
    end
  endtask

  task automatic test_init_hold();
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 0, 0, 0);
      checks++;
      if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(8)) begin
        errors++;
        $display("FAIL init_hold[%0d]: got v=%b c=%0d want v=1 c=8", i, o_credit_valid, o_credit_count);
      end
    end
    checks++;
    if (o_error !== 1'b1 || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL early_release: got e=%b p=%0d want e=1 p=0", o_error, o_pending);
    end
    step(0, 0, 1, 0);
    checks++;
    if (o_init_done !== 1'b1 || o_credit_valid !== 1'b0 || o_error !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: got d=%b v=%b e=%b want d=1 v=0 e=1", o_init_done, o_credit_valid, o_error);
    end
  endtask

  task automatic test_batch();
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, 0);
      checks++;
      if (o_pending !== CW'(i) || o_credit_valid !== 1'b0) begin
        errors++;
        $display("FAIL batch_accum[%0d]: got p=%0d v=%b want p=%0d v=0", i, o_pending, o_credit_valid, i);
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(4) || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL batch_launch: got v=%b c=%0d p=%0d want v=1 c=4 p=0", o_credit_valid, o_credit_count, o_pending);
    end
    step(0, 0, 1, 0);
    checks++;
    if (o_credit_valid !== 1'b0 || o_credit_count !== CW'(0)) begin
      errors++;
      $display("FAIL batch_accept: got v=%b c=%0d want v=0 c=0", o_credit_valid, o_credit_count);
    end
  endtask

  task automatic test_timeout_flush();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (o_pending !== CW'(2)) begin
      errors++;
      $display("FAIL tmo_pending: got %0d want 2", o_pending);
    end
    for (int k = 2; k <= 15; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (o_credit_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early[%0d]: got v=%b want v=0", k, o_credit_valid);
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(2) || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL tmo_launch: got v=%b c=%0d p=%0d want v=1 c=2 p=0", o_credit_valid, o_credit_count, o_pending);
    end
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(2) || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL flush_launch: got v=%b c=%0d p=%0d want v=1 c=2 p=0", o_credit_valid, o_credit_count, o_pending);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(4) || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL ovf_inflight: got v=%b c=%0d p=%0d want v=1 c=4 p=0", o_credit_valid, o_credit_count, o_pending);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (o_pending !== CW'(i) || o_error !== 1'b0 || o_credit_count !== CW'(4)) begin
        errors++;
        $display("FAIL ovf_fill[%0d]: got p=%0d e=%b c=%0d want p=%0d e=0 c=4", i, o_pending, o_error, o_credit_count, i);
      end
    end
    step(1, 0, 0, 0);
    checks++;
    if (o_error !== 1'b1 || o_pending !== CW'(4)) begin
      errors++;
      $display("FAIL ovf_drop: got e=%b p=%0d want e=1 p=4", o_error, o_pending);
    end
    step(0, 0, 1, 0);
    checks++;
    if (o_credit_valid !== 1'b0 || o_pending !== CW'(4)) begin
      errors++;
      $display("FAIL ovf_accept: got v=%b p=%0d want v=0 p=4", o_credit_valid, o_pending);
    end
    step(0, 0, 0, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(4) || o_pending !== CW'(0)) begin
      errors++;
      $display("FAIL ovf_relaunch: got v=%b c=%0d p=%0d want v=1 c=4 p=0", o_credit_valid, o_credit_count, o_pending);
    end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 1);
    checks++;
    if ({o_credit_valid, o_credit_count, o_pending, o_init_done, o_error} !== {1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear_values: got v=%b c=%0d p=%0d d=%b e=%b want all zero",
               o_credit_valid, o_credit_count, o_pending, o_init_done, o_error);
    end
    step(0, 0, 0, 0);
    checks++;
    if (o_credit_valid !== 1'b1 || o_credit_count !== CW'(8)) begin
      errors++;
      $display("FAIL clear_regrant: got v=%b c=%0d want v=1 c=8", o_credit_valid, o_credit_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_credit_valid !== 1'b0 || o_credit_count !== CW'(0)) begin
      errors++;
      $display("FAIL async_reset: got v=%b c=%0d want v=0 c=0", o_credit_valid, o_credit_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit r, f, k, c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) == 0);
      // Alternate between a busy sender and an eager one to reach overflow.
      k = ((i / 250) % 2 == 0) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 299) == 0);
      step(r, f, k, c);
      checks++;
      if (o_credit_valid !== (m_inflight > 0) || o_credit_count !== CW'(m_inflight) ||
          o_pending !== CW'(m_pend) || o_init_done !== m_done || o_error !== m_err) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b c=%0d p=%0d d=%b e=%b want v=%b c=%0d p=%0d d=%b e=%b",
                 i, o_credit_valid, o_credit_count, o_pending, o_init_done, o_error,
                 (m_inflight > 0), m_inflight, m_pend, m_done, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_hold();
    test_batch();
    test_timeout_flush();
    test_overflow();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
